imem_line_buffer: RTL and testbench

Instruction-memory responder on the fetch side of the pipeline: services fetch-stage word reads (imem_addr/imem_rmask) and returns imem_rdata/imem_resp. Holds one cache line of instructions; hits respond the next cycle, misses fetch the full line from backing memory as a burst of 64-bit beats. Sits between the fetch stage and the backing-memory arbiter.

---
 rtl/imem_line_buffer.sv | 191 +++++++++++++++++++
 tb/tb_imem_line_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_line_buffer.sv
// imem_line_buffer: single-line instruction buffer between the fetch stage and
// the backing-memory arbiter. A hit answers one cycle after the request. A miss
// refills the whole line as a burst of 64-bit beats, then answers.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   imem_addr/rmask   fetch word request (rmask != 0 means a read this cycle)
//   imem_rdata/resp   registered response word and one-cycle strobe
//   i_invalidate      drops the line-valid bit (fence.i)
//   bmem_addr/read    line-aligned burst request, held until bmem_ready
//   bmem_ready        burst request accepted
//   bmem_rdata/rvalid burst beats, ascending address order
//
// Optional feature: define IMEM_LB_STATS_EN to add the saturating hit_count and
// miss_count outputs. Without it the ports and counters are absent.

module imem_line_buffer #(
    parameter int unsigned BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic        i_invalidate,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    input  logic        bmem_ready,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_rvalid
`ifdef IMEM_LB_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned LINE_BYTES = 8 * BEATS;
    localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
    localparam int unsigned CNT_W      = $clog2(BEATS);
    localparam int unsigned WORDS      = 2 * BEATS;
    localparam int unsigned WSEL_W     = CNT_W + 1;
    localparam int unsigned TAG_W      = 32 - OFF_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

    state_t                    state_q, state_d;
    logic [31:0]               addr_q, addr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      valid_q, valid_d;
    logic [TAG_W-1:0]          tag_q, tag_d;
    logic                      inv_pend_q, inv_pend_d;
    logic [WORDS-1:0][31:0]    line_q, line_d;
    logic                      resp_d;
    logic [31:0]               rdata_d;
    logic                      bmem_read_d;
    logic [31:0]               bmem_addr_d;

    logic                      req_accept_c, hit_c, miss_c, beat_wr_c, fill_done_c;
    logic [WSEL_W-1:0]         beat_lo_c, beat_hi_c;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^imem_addr[1:0];

    // Request qualification; hit is suppressed by a same-cycle invalidate
    assign req_accept_c = ((state_q == IDLE) || (state_q == RESP)) && (imem_rmask != 4'b0);
    assign hit_c        = req_accept_c && valid_q && (tag_q == imem_addr[31:OFF_W]) && !i_invalidate;
    assign miss_c       = req_accept_c && !hit_c;
    assign beat_wr_c    = (state_q == FILL) && bmem_rvalid;
    assign fill_done_c  = beat_wr_c && (cnt_q == CNT_W'(BEATS - 1));
    assign beat_lo_c    = {cnt_q, 1'b0};
    assign beat_hi_c    = {cnt_q, 1'b1};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit_c) state_d = RESP; else if (miss_c) state_d = REQ;
            REQ:     if (bmem_ready) state_d = FILL;
            FILL:    if (fill_done_c) state_d = RESP;
            RESP:    if (hit_c) state_d = RESP; else if (miss_c) state_d = REQ; else state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        resp_d      = 1'b0;
        rdata_d     = '0;
        bmem_read_d = 1'b0;
        bmem_addr_d = '0;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        inv_pend_d  = inv_pend_q;
        line_d      = line_q;

        // Incoming beat merged so the final beat can be forwarded in the same cycle
        if (beat_wr_c) begin
            line_d[beat_lo_c] = bmem_rdata[31:0];
            line_d[beat_hi_c] = bmem_rdata[63:32];
            cnt_d             = cnt_q + CNT_W'(1);
        end

        if (req_accept_c) addr_d = imem_addr;

        if (hit_c) begin
            resp_d  = 1'b1;
            rdata_d = line_q[imem_addr[OFF_W-1:2]];
        end

        if (miss_c) begin
            bmem_read_d = 1'b1;
            bmem_addr_d = {imem_addr[31:OFF_W], OFF_W'(0)};
            inv_pend_d  = 1'b0;
        end

        if (state_q == REQ) begin
            if (bmem_ready) begin
                cnt_d = '0;
            end else begin
                bmem_read_d = 1'b1;
                bmem_addr_d = bmem_addr;
            end
        end

        // Invalidate seen mid-refill must leave the line invalid once it lands
        if (((state_q == REQ) || (state_q == FILL)) && i_invalidate) inv_pend_d = 1'b1;

        if (fill_done_c) begin
            resp_d  = 1'b1;
            rdata_d = line_d[addr_q[OFF_W-1:2]];
            tag_d   = addr_q[31:OFF_W];
            valid_d = !(inv_pend_q || i_invalidate);
        end

        if (i_invalidate) valid_d = 1'b0;
    end

    // Registered outputs and control state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_resp  <= 1'b0;
            imem_rdata <= '0;
            bmem_read  <= 1'b0;
            bmem_addr  <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            tag_q      <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            imem_resp  <= resp_d;
            imem_rdata <= rdata_d;
            bmem_read  <= bmem_read_d;
            bmem_addr  <= bmem_addr_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            inv_pend_q <= inv_pend_d;
        end
    end

    // Line data array; contents are meaningless until valid is set
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

`ifdef IMEM_LB_STATS_EN
    // Saturating hit/miss statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_c && (hit_count != 32'hFFFF_FFFF))   hit_count  <= hit_count + 32'd1;
            if (miss_c && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_line_buffer.sv
// Directed bench for imem_line_buffer (default BEATS=4, 32-byte lines).
module tb_imem_line_buffer;

    localparam int unsigned BEATS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        i_invalidate;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_ready;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
`ifdef IMEM_LB_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    imem_line_buffer #(.BEATS(BEATS)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rmask   (imem_rmask),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .i_invalidate (i_invalidate),
        .bmem_addr    (bmem_addr),
        .bmem_read    (bmem_read),
        .bmem_ready   (bmem_ready),
        .bmem_rdata   (bmem_rdata),
        .bmem_rvalid  (bmem_rvalid)
`ifdef IMEM_LB_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Backing-memory contents: two fixed instructions at the line base, a pattern elsewhere
    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h6000_0000) return 32'h0010_0093;
        if (a == 32'h6000_0004) return 32'h0000_0013;
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [63:0] beat_of(input logic [31:0] base, input int k);
        logic [31:0] a;
        a = base + 32'(k * 8);
        return {word_of(a + 32'd4), word_of(a)};
    endfunction

    // Full miss sequence with fixed-cycle expectations for every step
    task automatic fetch_miss(input logic [31:0] a, input int rdy_wait, input int inv_beat, input bit inv_req);
        logic [31:0] base;
        base = {a[31:5], 5'b0};
        imem_addr = a; imem_rmask = 4'hF; i_invalidate = inv_req;
        step();
        imem_rmask = 4'h0; i_invalidate = 1'b0;
        exp_misses++;
        chk("miss_no_early_resp", 32'(imem_resp), 32'd0);
        for (int i = 0; i < rdy_wait; i++) begin
            chk("req_read_held", 32'(bmem_read), 32'd1);
            chk("req_addr_held", bmem_addr, base);
            step();
        end
        chk("req_read", 32'(bmem_read), 32'd1);
        chk("req_addr", bmem_addr, base);
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        for (int k = 0; k < int'(BEATS); k++) begin
            chk("fill_read_low", 32'(bmem_read), 32'd0);
            chk("fill_no_resp", 32'(imem_resp), 32'd0);
            bmem_rvalid = 1'b1; bmem_rdata = beat_of(base, k); i_invalidate = (k == inv_beat);
            step();
        end
        bmem_rvalid = 1'b0; bmem_rdata = '0; i_invalidate = 1'b0;
        chk("miss_resp", 32'(imem_resp), 32'd1);
        chk("miss_rdata", imem_rdata, word_of({a[31:2], 2'b00}));
        step();
        chk("resp_one_cycle", 32'(imem_resp), 32'd0);
        chk("rdata_idle_zero", imem_rdata, 32'd0);
    endtask

    task automatic fetch_hit(input logic [31:0] a);
        imem_addr = a; imem_rmask = 4'hF;
        step();
        imem_rmask = 4'h0;
        exp_hits++;
        chk("hit_resp", 32'(imem_resp), 32'd1);
        chk("hit_rdata", imem_rdata, word_of(a));
        chk("hit_no_bmem", 32'(bmem_read), 32'd0);
        step();
        chk("hit_resp_drop", 32'(imem_resp), 32'd0);
    endtask

    initial begin
        rst = 1'b1; imem_addr = '0; imem_rmask = '0; i_invalidate = 1'b0;
        bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp", 32'(imem_resp), 32'd0);
        chk("rst_rdata", imem_rdata, 32'd0);
        chk("rst_bmem_read", 32'(bmem_read), 32'd0);
        chk("rst_bmem_addr", bmem_addr, 32'd0);
        rst = 1'b0;
        step();

        // Cold fetch
        fetch_miss(32'h6000_0000, 0, -1, 1'b0);

        // Back-to-back sequential hits across the rest of the line
        for (int i = 1; i < 8; i++) begin
            imem_addr = 32'h6000_0000 + 32'(i * 4); imem_rmask = 4'hF;
            step();
            exp_hits++;
            chk("seq_resp", 32'(imem_resp), 32'd1);
            chk("seq_rdata", imem_rdata, word_of(32'h6000_0000 + 32'(i * 4)));
            chk("seq_no_bmem", 32'(bmem_read), 32'd0);
        end
        imem_rmask = 4'h0;
        step();
        chk("seq_resp_drop", 32'(imem_resp), 32'd0);

        // Single line: next line misses, then the original line misses again
        fetch_miss(32'h6000_0020, 0, -1, 1'b0);
        fetch_miss(32'h6000_0000, 0, -1, 1'b0);

        // Slow bmem_ready, last word of the line (forwarded from the final beat)
        fetch_miss(32'h6000_003C, 5, -1, 1'b0);

        // Invalidate during the fill: answered, but the line stays invalid
        fetch_miss(32'h6000_0040, 0, 1, 1'b0);
        fetch_miss(32'h6000_0044, 0, -1, 1'b0);

        // Invalidate alongside a would-be hit forces a miss; the refill is then usable
        fetch_miss(32'h6000_0048, 0, -1, 1'b1);
        fetch_hit(32'h6000_004C);

        // Reset arriving with beat 2 of a fill
        imem_addr = 32'h6000_0080; imem_rmask = 4'hF;
        step();
        imem_rmask = 4'h0;
        chk("rstfill_req", 32'(bmem_read), 32'd1);
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1; bmem_rdata = beat_of(32'h6000_0080, k);
            step();
        end
        bmem_rvalid = 1'b1; bmem_rdata = beat_of(32'h6000_0080, 2);
        rst = 1'b1;
        #1;
        exp_hits = 0; exp_misses = 0;
        chk("rstfill_resp", 32'(imem_resp), 32'd0);
        chk("rstfill_rdata", imem_rdata, 32'd0);
        chk("rstfill_read", 32'(bmem_read), 32'd0);
        chk("rstfill_addr", bmem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bmem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            step();
            chk("stray_beat_resp", 32'(imem_resp), 32'd0);
            chk("stray_beat_read", 32'(bmem_read), 32'd0);
        end
        bmem_rvalid = 1'b0; bmem_rdata = '0;
        fetch_miss(32'h6000_0084, 0, -1, 1'b0);

`ifdef IMEM_LB_STATS_EN
        chk("stat_hits", hit_count, 32'(exp_hits));
        chk("stat_misses", miss_count, 32'(exp_misses));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
